// File: rtl/lut_ff_mux_pkg.sv
// Shared types and helpers for the LUT/FF/mux lane array.
package lut_ff_mux_pkg;
  localparam int MAX_CHANNELS = 16;

  typedef enum logic [1:0] {CFG_IDLE, CFG_SHIFT, CFG_DONE} cfg_state_t;

  function automatic int lut_mask_w(input int k);
    return 1 << k;
  endfunction
endpackage

// File: rtl/lut_ff_mux_lane.sv
// One lane: K-input LUT, enable-gated register chain and a comb/registered output mux.
module lut_ff_mux_lane
  import lut_ff_mux_pkg::*;
#(
  parameter int LUT_K      = 4,
  parameter int PIPE_DEPTH = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [lut_mask_w(LUT_K)-1:0] mask_i,
  input  logic [LUT_K-1:0]             in_i,
  input  logic                         mux_sel_i,
  input  logic                         ff_en_i,
  input  logic                         valid_i,
  output logic                         q_o
);
  logic                  lut;
  logic [PIPE_DEPTH-1:0] stg_q, stg_d;

  assign lut = mask_i[in_i];

  always_comb begin
    stg_d = stg_q;
    if (ff_en_i) begin
      stg_d[0] = lut;
      for (int n = 1; n < PIPE_DEPTH; n++) stg_d[n] = stg_q[n-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) stg_q <= '0;
    else     stg_q <= stg_d;
  end

  // Output stays low until a complete mask set has been committed.
  assign q_o = valid_i & (mux_sel_i ? lut : stg_q[PIPE_DEPTH-1]);
endmodule

// File: rtl/lut_ff_mux_array.sv
// CHANNELS LUT/FF/mux lanes with serial mask loading through a shadow chain.
// Optional LUT_FF_MUX_CFG_READBACK_EN adds cfg_dout, streaming the displaced active masks.
module lut_ff_mux_array
  import lut_ff_mux_pkg::*;
#(
  parameter int CHANNELS   = 4,
  parameter int LUT_K      = 4,
  parameter int PIPE_DEPTH = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS*LUT_K-1:0] in,
  input  logic [CHANNELS-1:0]       mux_sel,
  input  logic [CHANNELS-1:0]       ff_en,
  input  logic                      cfg_start,
  input  logic                      cfg_din,
  output logic                      cfg_busy,
  output logic                      cfg_done,
  output logic                      cfg_valid,
`ifdef LUT_FF_MUX_CFG_READBACK_EN
  output logic                      cfg_dout,
`endif
  output logic [CHANNELS-1:0]       Q
);
  localparam int W     = lut_mask_w(LUT_K);
  localparam int TOTAL = CHANNELS * W;
  localparam int CW    = $clog2(TOTAL + 1);

  cfg_state_t                 state_q, state_d;
  logic [CW-1:0]              cnt_q, cnt_d;
  logic [TOTAL-1:0]           shadow_q, shadow_d;
  logic [CHANNELS-1:0][W-1:0] mask_q;
  logic                       valid_q;

  // Shift right with new bits entering at the top, so the first bit lands in lane 0 bit 0.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    case (state_q)
      CFG_IDLE: if (cfg_start) begin
        state_d = CFG_SHIFT;
        cnt_d   = '0;
      end
      CFG_SHIFT: begin
        shadow_d = {cfg_din, shadow_q[TOTAL-1:1]};
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == CW'(TOTAL - 1)) begin
          state_d = CFG_DONE;
          cnt_d   = '0;
        end
      end
      CFG_DONE: state_d = CFG_IDLE;
      default:  state_d = CFG_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= CFG_IDLE;
      cnt_q    <= '0;
      shadow_q <= '0;
      mask_q   <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      if (state_q == CFG_DONE) begin
        mask_q  <= shadow_q;
        valid_q <= 1'b1;
      end
    end
  end

  assign cfg_busy  = (state_q == CFG_SHIFT);
  assign cfg_done  = (state_q == CFG_DONE);
  assign cfg_valid = valid_q;

`ifdef LUT_FF_MUX_CFG_READBACK_EN
  localparam int IW = $clog2(TOTAL);
  logic [TOTAL-1:0] mask_flat;
  logic [IW-1:0]    rb_q, rb_d;

  assign mask_flat = mask_q;
  assign rb_d      = cfg_busy ? rb_q + IW'(1) : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rb_q <= '0;
    else     rb_q <= rb_d;
  end

  // Independent pointer into the active masks, so readback never disturbs them.
  assign cfg_dout = cfg_busy & mask_flat[rb_q];
`endif

  for (genvar i = 0; i < CHANNELS; i++) begin : g_lane
    lut_ff_mux_lane #(
      .LUT_K      (LUT_K),
      .PIPE_DEPTH (PIPE_DEPTH)
    ) u_lane (
      .clk       (clk),
      .rst       (rst),
      .mask_i    (mask_q[i]),
      .in_i      (in[i*LUT_K +: LUT_K]),
      .mux_sel_i (mux_sel[i]),
      .ff_en_i   (ff_en[i]),
      .valid_i   (valid_q),
      .q_o       (Q[i])
    );
  end
endmodule

// File: doc/lut_ff_mux_array.md
Name: lut_ff_mux_array

Overview:
Parametrised successor of the single LUT/FF/mux cell. It provides CHANNELS independent K-input LUT cells. Each cell has a registered path of programmable depth and a per-channel output mux choosing the combinational LUT value or the registered value. LUT masks load through a serial configuration shift chain under a small FSM, mirroring fabric bitstream loading, so one block serves as a multi-lane benchmark for fabric bring-up and bitstream tests.

Parameters:
CHANNELS, 4, number of independent LUT/FF/mux lanes (1..16)
LUT_K, 4, LUT input count per lane; mask width 2**LUT_K (2..6)
PIPE_DEPTH, 1, register stages on the registered path (1..4)

Ports:
clk  input  1  single clock, rising edge
rst  input  1  asynchronous active-high reset
in  input  CHANNELS*LUT_K  lane i uses in[i*LUT_K +: LUT_K]
mux_sel  input  CHANNELS  per lane: 1 = combinational LUT output, 0 = registered output
ff_en  input  CHANNELS  per-lane register-chain enable
cfg_start  input  1  pulse: begin mask load
cfg_din  input  1  serial mask bit, sampled when cfg_busy=1
cfg_busy  output  1  high during shift
cfg_done  output  1  one-cycle pulse when load completes
cfg_valid  output  1  masks loaded since last reset
Q  output  CHANNELS  lane outputs

Behaviour:
- Reset (async assert; deassert synchronised to clk by the caller): all masks=0, all register stages=0, FSM=IDLE, bit counter=0, cfg_busy=0, cfg_done=0, cfg_valid=0, Q=0.
- LUT: lut_i = mask_i[in_i], where in_i is an unsigned index. Combinational, no latency.
- Registered path: stage0 <= lut_i when ff_en[i]; stage n <= stage n-1 when ff_en[i]. Output = last stage. Latency is PIPE_DEPTH enabled edges. ff_en=0 holds all stages.
- Q[i] = cfg_valid ? (mux_sel[i] ? lut_i : reg_i) : 0. Combinational select; mux_sel change is visible in the same cycle.
- FSM IDLE -> SHIFT on cfg_start.
- SHIFT: each cycle, shift cfg_din into the chain. The chain is LSB-first, lane 0 first. Total TOTAL = CHANNELS*2**LUT_K bits. Counter width = clog2(TOTAL+1).
- The counter hits TOTAL-1 while in SHIFT -> DONE. DONE lasts one cycle: cfg_done=1, cfg_valid<=1 -> IDLE.
- cfg_busy = (state==SHIFT).
- Masks are updated in a shadow register and committed to the active masks only in DONE. A partial load never disturbs Q.
- cfg_start while in SHIFT or DONE is ignored.
- Reload while cfg_valid=1: active masks and Q keep operating on the old masks until DONE commits.
- rst mid-SHIFT: everything returns to reset values and the partial shadow is discarded.
- Register stages keep running during a reload; they follow the old masks until commit.

Optional Feature:
- Macro LUT_FF_MUX_CFG_READBACK_EN.
- When defined: extra output cfg_dout (1 bit) presents the active-mask bit being displaced in shift order. Readback is non-destructive: a separate readback pointer indexes the active masks. This lets a full load also return the previous configuration. cfg_dout=0 outside SHIFT and after reset.
- When undefined: port absent, no readback logic.

Decomposition:
- Shared package lut_ff_mux_pkg holds:
  - cfg_state_t enum {CFG_IDLE, CFG_SHIFT, CFG_DONE}
  - function lut_mask_w(k) = 2**k
  - localparam MAX_CHANNELS=16
- One natural sub-module, lut_ff_mux_lane: a single LUT, register chain and mux, instantiated CHANNELS times by generate.
- The config FSM, counter and shadow register stay in the top.

Test Plan:
- Reset, no load: any in/mux_sel -> Q=4'b0000, cfg_valid=0.
- Load 0x6996 (4-input parity) to all 4 lanes (64 bits).
  - cfg_busy high exactly 64 cycles; cfg_done pulses once; cfg_valid=1.
  - Lane 0, mux_sel=1: in=4'b0011 -> Q[0]=0; in=4'b0001 -> Q[0]=1.
- PIPE_DEPTH=2, mux_sel=0, ff_en=1: in step 0000->0001 -> Q[0] rises exactly 2 edges later.
  - Then ff_en=0: Q holds 1 despite in=0011.
- Reload with 0x0000 while lanes run 0x6996: Q keeps parity behaviour for all 64 shift cycles and switches to 0 the cycle after cfg_done.
- rst asserted at shift bit 20: cfg_busy drops immediately, cfg_valid=0, Q=0. A subsequent full load with 0xFFFF -> Q=1 for any in with mux_sel=1.
- READBACK_EN: load 0x6996, then reload 0x0000 -> cfg_dout streams 0x6996 LSB-first, lane 0 first.
